enc_4x2_handshake: RTL and testbench



---
 rtl/enc_4x2_handshake_if.sv | 28 ++
 rtl/enc_4x2_handshake.sv | 122 ++++++++++++
 tb/tb_enc_4x2_handshake.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/enc_4x2_handshake_if.sv
// Handshake bundle between request sources, the 4-to-2 encoder and the code consumer.
// The master modport is the encoder side; slave is the source/consumer side.
interface enc_4x2_handshake_if;
    logic [3:0] req_i;
    logic       ready_i;
    logic [1:0] code_o;
    logic       valid_o;
    logic [3:0] pend_o;
    logic       multi_o;

    modport master (
        input  req_i,
        input  ready_i,
        output code_o,
        output valid_o,
        output pend_o,
        output multi_o
    );

    modport slave (
        output req_i,
        output ready_i,
        input  code_o,
        input  valid_o,
        input  pend_o,
        input  multi_o
    );
endinterface

// File: rtl/enc_4x2_handshake.sv
// Sequential 4-to-2 priority encoder: collects requests and offers one code at a time over valid/ready.
// Define ENC_ROUND_ROBIN_EN for round-robin arbitration instead of fixed priority (PRIO_HIGH).
module enc_4x2_handshake #(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    enc_4x2_handshake_if.master         bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] pend;
    logic [3:0] pend_next;
    logic [3:0] gmask;
    logic [1:0] code;
    logic [1:0] code_next;
    logic [1:0] win;
    logic       multi;
    logic       hs;

    assign hs        = (state == OFFER) & bus.ready_i;
    assign gmask     = hs ? (4'b0001 << code) : 4'b0000;
    // A request on the bit being granted this cycle survives the clear.
    assign pend_next = (pend & ~gmask) | bus.req_i;

`ifdef ENC_ROUND_ROBIN_EN
    logic [1:0] rr;
    logic [1:0] rr_next;

    function automatic logic [1:0] winner_rr(input logic [3:0] p, input logic [1:0] start);
        logic       found;
        logic [1:0] idx;
        winner_rr = start;
        found     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && p[idx]) begin
                winner_rr = idx;
                found     = 1'b1;
            end
        end
    endfunction

    assign rr_next = hs ? code + 2'd1 : rr;
    assign win     = winner_rr(pend_next, rr_next);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr <= 2'd0;
        end else begin
            rr <= rr_next;
        end
    end
`else
    // The last set bit visited in the scan order is the winner.
    function automatic logic [1:0] winner_fixed(input logic [3:0] p);
        winner_fixed = 2'd0;
        if (PRIO_HIGH) begin
            for (int i = 0; i < 4; i++) begin
                if (p[i]) winner_fixed = 2'(i);
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (p[i]) winner_fixed = 2'(i);
            end
        end
    endfunction

    assign win = winner_fixed(pend_next);
`endif

    always_comb begin
        state_next = state;
        code_next  = code;
        case (state)
            IDLE: begin
                if (pend_next != 4'b0000) begin
                    state_next = OFFER;
                    code_next  = win;
                end
            end
            OFFER: begin
                if (hs) begin
                    if (pend_next != 4'b0000) begin
                        code_next = win;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= 4'b0000;
            code  <= 2'd0;
            multi <= 1'b0;
        end else begin
            state <= state_next;
            pend  <= pend_next;
            code  <= code_next;
            multi <= |(pend_next & (pend_next - 4'd1));
        end
    end

    assign bus.code_o  = code;
    assign bus.valid_o = (state == OFFER);
    assign bus.pend_o  = pend;
    assign bus.multi_o = multi;

endmodule

// File: tb/tb_enc_4x2_handshake.sv
// Bench for enc_4x2_handshake: two instances (PRIO_HIGH=1 and 0) share stimulus and are
// compared every cycle against a request-set reference model plus directed expectations.
module tb_enc_4x2_handshake;

`ifdef ENC_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       ready;

    int checks = 0;
    int errors = 0;

    enc_4x2_handshake_if bus_hi ();
    enc_4x2_handshake_if bus_lo ();

    assign bus_hi.req_i   = req;
    assign bus_hi.ready_i = ready;
    assign bus_lo.req_i   = req;
    assign bus_lo.ready_i = ready;

    enc_4x2_handshake #(.PRIO_HIGH(1'b1)) dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_hi)
    );

    enc_4x2_handshake #(.PRIO_HIGH(1'b0)) dut_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_lo)
    );

    always #5 clk = ~clk;

    // Reference state per instance: index 0 = PRIO_HIGH=1, index 1 = PRIO_HIGH=0.
    logic [3:0] m_pend [2];
    logic       m_valid[2];
    logic [1:0] m_code [2];
    int         m_rr   [2];

    function automatic logic [1:0] ref_winner(input int d, input logic [3:0] p, input int rr);
        int order[4];
        for (int k = 0; k < 4; k++) begin
            if (RR)          order[k] = (rr + k) % 4;
            else if (d == 0) order[k] = 3 - k;
            else             order[k] = k;
        end
        for (int k = 0; k < 4; k++) begin
            if (p[order[k]]) return 2'(order[k]);
        end
        return 2'd0;
    endfunction

    function automatic int ones(input logic [3:0] p);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(p[i]);
        return n;
    endfunction

    task automatic model_step(input int d);
        logic       granted;
        logic [3:0] p;
        if (!rst_n) begin
            m_pend[d]  = 4'b0000;
            m_valid[d] = 1'b0;
            m_code[d]  = 2'd0;
            m_rr[d]    = 0;
            return;
        end
        granted = m_valid[d] && ready;
        p       = m_pend[d];
        if (granted) begin
            p[m_code[d]] = 1'b0;
            m_rr[d]      = (int'(m_code[d]) + 1) % 4;
        end
        p = p | req;
        if (granted || !m_valid[d]) begin
            if (p != 4'b0000) begin
                m_valid[d] = 1'b1;
                m_code[d]  = ref_winner(d, p, m_rr[d]);
            end else begin
                m_valid[d] = 1'b0;
            end
        end
        m_pend[d] = p;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("model_code_hi",  {2'b00, bus_hi.code_o},  {2'b00, m_code[0]});
        check("model_valid_hi", {3'b000, bus_hi.valid_o}, {3'b000, m_valid[0]});
        check("model_pend_hi",  bus_hi.pend_o,           m_pend[0]);
        check("model_multi_hi", {3'b000, bus_hi.multi_o}, {3'b000, ones(m_pend[0]) >= 2});
        check("model_code_lo",  {2'b00, bus_lo.code_o},  {2'b00, m_code[1]});
        check("model_valid_lo", {3'b000, bus_lo.valid_o}, {3'b000, m_valid[1]});
        check("model_pend_lo",  bus_lo.pend_o,           m_pend[1]);
        check("model_multi_lo", {3'b000, bus_lo.multi_o}, {3'b000, ones(m_pend[1]) >= 2});
    endtask

    // Inputs change only after the falling edge; the model steps on the same rising edge as the DUTs.
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic rd);
        rst_n = r;
        req   = rq;
        ready = rd;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic checkBoth(input string tag, input logic [3:0] code_hi, input logic [3:0] code_lo,
                             input logic valid, input logic [3:0] pend);
        check({tag, "_code_hi"}, {2'b00, bus_hi.code_o}, code_hi);
        check({tag, "_code_lo"}, {2'b00, bus_lo.code_o}, code_lo);
        check({tag, "_valid_hi"}, {3'b000, bus_hi.valid_o}, {3'b000, valid});
        check({tag, "_valid_lo"}, {3'b000, bus_lo.valid_o}, {3'b000, valid});
        check({tag, "_pend_hi"}, bus_hi.pend_o, pend);
        check({tag, "_pend_lo"}, bus_lo.pend_o, pend);
    endtask

    initial begin
        logic [3:0] burst_hi[3];
        logic [3:0] burst_lo[3];
        logic [3:0] stream_hi;
        logic [3:0] stream_lo;

        if (RR) begin
            burst_hi = '{4'd3, 4'd0, 4'd1};
            burst_lo = '{4'd3, 4'd0, 4'd1};
        end else begin
            burst_hi = '{4'd3, 4'd1, 4'd0};
            burst_lo = '{4'd0, 4'd1, 4'd3};
        end

        $display("[TB] reset with all requests asserted");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1111, 1'b0);
        checkBoth("reset", 4'd0, 4'd0, 1'b0, 4'b0000);
        check("reset_multi_hi", {3'b000, bus_hi.multi_o}, 4'd0);

        applyStimulus(1'b1, 4'b1111, 1'b0);
        checkBoth("release", RR ? 4'd0 : 4'd3, 4'd0, 1'b1, 4'b1111);
        check("release_multi_hi", {3'b000, bus_hi.multi_o}, 4'd1);

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'b0000, 1'b1);
        checkBoth("drained", bus_hi.valid_o ? 4'hf : {2'b00, bus_hi.code_o},
                  {2'b00, bus_lo.code_o}, 1'b0, 4'b0000);

        $display("[TB] single pulse under backpressure");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, (k == 0) ? 4'b0100 : 4'b0000, 1'b0);
            checkBoth("hold", 4'd2, 4'd2, 1'b1, 4'b0100);
        end
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkBoth("pulse_done", 4'd2, 4'd2, 1'b0, 4'b0000);

        $display("[TB] burst drain");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, (k == 0) ? 4'b1011 : 4'b0000, 1'b1);
            check("burst_code_hi", {2'b00, bus_hi.code_o}, burst_hi[k]);
            check("burst_code_lo", {2'b00, bus_lo.code_o}, burst_lo[k]);
            check("burst_multi_hi", {3'b000, bus_hi.multi_o}, {3'b000, k < 2});
            check("burst_multi_lo", {3'b000, bus_lo.multi_o}, {3'b000, k < 2});
        end
        applyStimulus(1'b1, 4'b0000, 1'b1);
        check("burst_idle_hi", {3'b000, bus_hi.valid_o}, 4'd0);
        check("burst_idle_lo", {3'b000, bus_lo.valid_o}, 4'd0);

        $display("[TB] set wins over grant");
        applyStimulus(1'b1, 4'b0010, 1'b0);
        checkBoth("collide_pre", 4'd1, 4'd1, 1'b1, 4'b0010);
        applyStimulus(1'b1, 4'b0010, 1'b1);
        checkBoth("collide", 4'd1, 4'd1, 1'b1, 4'b0010);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkBoth("collide_done", 4'd1, 4'd1, 1'b0, 4'b0000);

        $display("[TB] reset while offering");
        applyStimulus(1'b1, 4'b1110, 1'b0);
        check("midoffer_pend_hi", bus_hi.pend_o, 4'b1110);
        check("midoffer_valid_lo", {3'b000, bus_lo.valid_o}, 4'd1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkBoth("midreset", 4'd0, 4'd0, 1'b0, 4'b0000);
        check("midreset_multi_lo", {3'b000, bus_lo.multi_o}, 4'd0);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkBoth("post_reset_idle", 4'd0, 4'd0, 1'b0, 4'b0000);

        $display("[TB] saturated requests with constant ready");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 4'b1111, 1'b1);
            stream_hi = RR ? 4'(k % 4) : 4'd3;
            stream_lo = RR ? 4'(k % 4) : 4'd0;
            check("stream_code_hi", {2'b00, bus_hi.code_o}, stream_hi);
            check("stream_code_lo", {2'b00, bus_lo.code_o}, stream_lo);
        end

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom % 50) != 0,
                          ($urandom % 3 == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                          ($urandom % 4) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
